dcache_dram_bridge: RTL and testbench
=====================================

Name: dcache_dram_bridge

Overview:
- Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line.
- Sits directly downstream of the data RAM wrapper's DRAM-side port (valid_dram/rw_dram/addr_dram/din_dram in; dout_dram/ready_dram out).
- Forwards misses and all writes to a word-wide backing-memory request/ack port.
- Read hits avoid backing-memory latency entirely.

Parameters:
- INDEX_BITS, 10: line index width; 2^INDEX_BITS lines.
- ADDR_W, 27: byte-address width of addr_dram.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- valid_dram  in  1  request valid; level, held by requester until ready_dram.
- rw_dram  in  1  1 = write, 0 = read.
- addr_dram  in  ADDR_W  byte address; bits [1:0] ignored.
- din_dram  in  32  write data.
- dout_dram  out  32  read data; valid in the ready_dram cycle.
- ready_dram  out  1  one-cycle completion pulse.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  backing write enable.
- mem_addr  out  ADDR_W-2  word address (addr[ADDR_W-1:2]).
- mem_wdata  out  32  backing write data.
- mem_rdata  in  32  backing read data; valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2]; tag = addr[ADDR_W-1:INDEX_BITS+2].
- Storage: data/tag RAMs with synchronous read; valid bits in the same indexed store.
- All outputs are registered. Reset values: ready_dram=0, dout_dram=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- FLUSH (entered on rst):
  - Counter walks index 0 .. 2^INDEX_BITS-1, clearing one valid bit per cycle.
  - valid_dram is ignored throughout; FLUSH -> IDLE after the last index.
- IDLE: on valid_dram=1, latch addr/rw/din, issue tag/data RAM read -> LOOKUP.
- LOOKUP:
  - hit = valid && tag match.
  - Read hit: dout_dram <= line data, ready_dram <= 1 -> DONE. Latency: valid sampled at edge T, ready_dram high for exactly cycle T+2.
  - Read miss -> MISS_RD.
  - Write (hit or miss) -> WRITE.
- MISS_RD:
  - mem_req=1, mem_we=0, mem_addr=latched word address, held stable until mem_ack.
  - On mem_ack: write line (valid=1, tag, mem_rdata); dout_dram <= mem_rdata; ready_dram pulse -> DONE.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata=latched din, held until mem_ack.
  - Line data is updated on the ack edge only if LOOKUP hit; a miss does not allocate.
  - On mem_ack: ready_dram pulse -> DONE.
- DONE: one cycle, ready_dram=0, valid_dram ignored -> IDLE. This absorbs the requester's valid deassertion lag; a write re-presented afterwards is simply re-issued, which is harmless under write-through.
- mem_req drops the cycle after mem_ack. mem_ack while mem_req=0 is ignored.
- Request fields changing while a request is in flight are ignored; latched values govern.
- rst mid-operation: all outputs return to reset values at the next edge and FLUSH restarts. Any pending mem_ack is ignored; the backing memory is reset in the same domain.
- Simultaneous rst and mem_ack: rst wins, the line is not filled, no ready_dram pulse.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments once per LOOKUP, reads and writes alike, and saturates at 0xFFFFFFFF.
  - Both clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with INDEX_BITS=10 -> ready_dram/mem_req stay 0 for 1024 cycles. A read held from reset release is served only after FLUSH completes.
- Read 0x0000100 (miss), memory acks 0xDEADBEEF after 3 cycles -> mem_addr=0x40, we=0, dout_dram=0xDEADBEEF with ready_dram. Re-read -> no mem_req, ready at T+2, dout 0xDEADBEEF.
- Write 0x12345678 to 0x0000100 (hit) -> mem_req we=1, mem_addr=0x40, mem_wdata=0x12345678. Following read hits and returns 0x12345678 with no mem_req.
- Write to 0x0002000 (miss), then read 0x0002000 -> read issues mem_req (no allocate on write miss).
- Alternating reads of 0x0000100 and 0x0001100 (same index, different tag) -> every access misses and issues mem_req. With DCACHE_STATS_EN, after 4 reads miss_count=4, hit_count=0.
- Assert rst while mem_req=1 in MISS_RD, then pulse mem_ack -> mem_req=0 next cycle, no ready_dram pulse, line not filled, FLUSH restarts.

Source files
------------

// File: rtl/dcache_dram_bridge.sv
// Direct-mapped write-through, no-write-allocate cache bridging the DRAM-side port to a word-wide backing memory.
// Optional hit/miss counters are compiled in with `define DCACHE_STATS_EN.
module dcache_dram_bridge #(
  parameter int INDEX_BITS = 10,
  parameter int ADDR_W     = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_dram,
  input  logic              rw_dram,
  input  logic [ADDR_W-1:0] addr_dram,
  input  logic [31:0]       din_dram,
  output logic [31:0]       dout_dram,
  output logic              ready_dram,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - 2 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [2:0] {FLUSH, IDLE, LOOKUP, MISS_RD, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-3:0]       waddr_q, waddr_d;
  logic                    rw_q, rw_d;
  logic [31:0]             din_q, din_d;
  logic                    hit_q, hit_d;
  logic [31:0]             dout_q, dout_d;
  logic                    ready_q, ready_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_W-3:0]       maddr_q, maddr_d;
  logic [31:0]             wdata_q, wdata_d;

  logic [31:0]             data_mem [LINES];
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic                    vld_mem  [LINES];
  logic [31:0]             rd_data_q;
  logic [TAG_W-1:0]        rd_tag_q;
  logic                    rd_vld_q;
  logic                    rd_en;
  logic                    wr_en;
  logic [INDEX_BITS-1:0]   wr_idx;
  logic                    wr_vld;
  logic [TAG_W-1:0]        wr_tag;
  logic [31:0]             wr_data;
  logic                    hit;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [TAG_W-1:0]        tag_q;
  logic                    unused_byte_bits;

  assign unused_byte_bits = ^addr_dram[1:0];
  assign idx_q = waddr_q[INDEX_BITS-1:0];
  assign tag_q = waddr_q[ADDR_W-3:INDEX_BITS];
  assign hit   = rd_vld_q && (rd_tag_q == tag_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    rw_d    = rw_q;
    din_d   = din_q;
    hit_d   = hit_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_vld  = 1'b1;
    wr_tag  = tag_q;
    wr_data = din_q;
    case (state_q)
      FLUSH: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q;
        wr_vld  = 1'b0;
        wr_tag  = '0;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        if (valid_dram) begin
          waddr_d = addr_dram[ADDR_W-1:2];
          rw_d    = rw_dram;
          din_d   = din_dram;
          rd_en   = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = hit;
        if (!rw_q && hit) begin
          dout_d  = rd_data_q;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          req_d   = 1'b1;
          we_d    = rw_q;
          maddr_d = waddr_q;
          if (rw_q) wdata_d = din_q;
          state_d = rw_q ? WRITE : MISS_RD;
        end
      end
      MISS_RD: begin
        if (mem_ack && req_q) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          dout_d  = mem_rdata;
          ready_d = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_ack && req_q) begin
          // Write misses leave the line untouched (no allocate).
          wr_en   = hit_q;
          ready_d = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FLUSH;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Request latches and line storage carry no reset; FLUSH invalidates lines.
  always_ff @(posedge clk) begin
    waddr_q <= waddr_d;
    rw_q    <= rw_d;
    din_q   <= din_d;
    if (rd_en) begin
      rd_data_q <= data_mem[addr_dram[INDEX_BITS+1:2]];
      rd_tag_q  <= tag_mem[addr_dram[INDEX_BITS+1:2]];
      rd_vld_q  <= vld_mem[addr_dram[INDEX_BITS+1:2]];
    end
    if (wr_en && !rst) begin
      data_mem[wr_idx] <= wr_data;
      tag_mem[wr_idx]  <= wr_tag;
      vld_mem[wr_idx]  <= wr_vld;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && hit_cnt_q != 32'hFFFF_FFFF)       hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (!hit && miss_cnt_q != 32'hFFFF_FFFF)     miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign dout_dram  = dout_q;
  assign ready_dram = ready_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_dcache_dram_bridge.sv
// Directed bench for dcache_dram_bridge: flush, read miss/hit, write hit/miss, conflict misses, reset mid-request.
module tb_dcache_dram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_dram;
  logic        rw_dram;
  logic [26:0] addr_dram;
  logic [31:0] din_dram;
  logic [31:0] dout_dram;
  logic        ready_dram;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_dram_bridge #(.INDEX_BITS(10), .ADDR_W(27)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_dram (valid_dram),
    .rw_dram    (rw_dram),
    .addr_dram  (addr_dram),
    .din_dram   (din_dram),
    .dout_dram  (dout_dram),
    .ready_dram (ready_dram),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Presents one request from IDLE and answers any backing request after ack_delay cycles.
  // ready_cyc counts edges from presentation (1 = the IDLE sampling edge); -1 on timeout.
  task automatic do_access(input bit rw, input logic [26:0] a, input logic [31:0] d,
                           input int ack_delay, input logic [31:0] rdata,
                           output bit req_seen, output logic req_we, output logic [24:0] req_addr,
                           output logic [31:0] req_wdata, output int ready_cyc,
                           output logic [31:0] dout, output bit ready_after);
    int req_cnt;
    req_seen  = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    ready_cyc = -1;
    dout      = '0;
    req_cnt   = 0;
    @(negedge clk);
    valid_dram = 1'b1;
    rw_dram    = rw;
    addr_dram  = a;
    din_dram   = d;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (ready_dram) begin
        ready_cyc = c;
        dout      = dout_dram;
        break;
      end
      if (mem_req) begin
        req_seen  = 1'b1;
        req_we    = mem_we;
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
        req_cnt++;
        mem_ack   = (req_cnt == ack_delay);
        mem_rdata = rdata;
      end else begin
        mem_ack = 1'b0;
      end
    end
    valid_dram = 1'b0;
    mem_ack    = 1'b0;
    @(posedge clk);
    #1;
    ready_after = ready_dram;
  endtask

  task automatic test_reset();
    int quiet;
    int wait_cyc;
    rst = 1'b1; valid_dram = 1'b0; rw_dram = 1'b0; addr_dram = '0; din_dram = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_dram !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready_dram); end
    checks++; if (dout_dram !== 32'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0", dout_dram); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 25'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
`ifdef DCACHE_STATS_EN
    checks++; if (hit_count !== 0 || miss_count !== 0) begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
    // Read held from reset release must wait out the flush.
    @(negedge clk);
    valid_dram = 1'b1; rw_dram = 1'b0; addr_dram = 27'h0000200;
    rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 1024; c++) begin
      @(posedge clk);
      #1;
      if (!mem_req && !ready_dram) quiet++;
    end
    checks++; if (quiet != 1024) begin errors++; $display("FAIL flush_quiet got=%0d exp=1024", quiet); end
    wait_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (mem_req) begin wait_cyc = c; break; end
    end
    checks++; if (wait_cyc < 0) begin errors++; $display("FAIL flush_then_serve got=timeout exp=mem_req"); end
    checks++; if (mem_addr !== 25'h80) begin errors++; $display("FAIL flush_req_addr got=%h exp=80", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0200;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checks++; if (ready_dram !== 1'b1 || dout_dram !== 32'h0000_0200) begin
      errors++; $display("FAIL flush_read got=%b/%h exp=1/00000200", ready_dram, dout_dram); end
    valid_dram = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_read_miss_hit();
    bit rs, ra; logic we; logic [24:0] ma; logic [31:0] wd, dv; int rc;
    do_access(1'b0, 27'h0000100, 32'h0, 3, 32'hDEADBEEF, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || we !== 1'b0 || ma !== 25'h40) begin
      errors++; $display("FAIL miss_req got=req%b we%b addr%h exp=req1 we0 addr40", rs, we, ma); end
    checks++; if (rc < 0 || dv !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got=%h cyc%0d exp=deadbeef", dv, rc); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL miss_pulse got=%b exp=0", ra); end
    do_access(1'b0, 27'h0000100, 32'h0, 1, 32'h0, rs, we, ma, wd, rc, dv, ra);
    checks++; if (rs) begin errors++; $display("FAIL hit_noreq got=req1 exp=req0"); end
    checks++; if (rc != 2) begin errors++; $display("FAIL hit_latency got=%0d exp=2", rc); end
    checks++; if (dv !== 32'hDEADBEEF) begin errors++; $display("FAIL hit_data got=%h exp=deadbeef", dv); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL hit_pulse got=%b exp=0", ra); end
  endtask

  task automatic test_write();
    bit rs, ra; logic we; logic [24:0] ma; logic [31:0] wd, dv; int rc;
    do_access(1'b1, 27'h0000100, 32'h12345678, 2, 32'h0, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || we !== 1'b1 || ma !== 25'h40 || wd !== 32'h12345678) begin
      errors++; $display("FAIL wr_hit_req got=req%b we%b addr%h data%h exp=req1 we1 addr40 data12345678", rs, we, ma, wd); end
    checks++; if (rc < 0) begin errors++; $display("FAIL wr_hit_ready got=timeout exp=pulse"); end
    do_access(1'b0, 27'h0000100, 32'h0, 1, 32'h0, rs, we, ma, wd, rc, dv, ra);
    checks++; if (rs || rc != 2 || dv !== 32'h12345678) begin
      errors++; $display("FAIL wr_hit_readback got=req%b cyc%0d %h exp=req0 cyc2 12345678", rs, rc, dv); end
    do_access(1'b1, 27'h0002000, 32'hA5A5A5A5, 1, 32'h0, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || we !== 1'b1 || ma !== 25'h800 || wd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL wr_miss_req got=req%b we%b addr%h data%h exp=req1 we1 addr800 dataa5a5a5a5", rs, we, ma, wd); end
    do_access(1'b0, 27'h0002000, 32'h0, 2, 32'h0BADF00D, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || we !== 1'b0 || ma !== 25'h800) begin
      errors++; $display("FAIL no_allocate got=req%b we%b addr%h exp=req1 we0 addr800", rs, we, ma); end
    checks++; if (dv !== 32'h0BADF00D) begin errors++; $display("FAIL no_alloc_data got=%h exp=0badf00d", dv); end
  endtask

  task automatic test_conflict();
    bit rs, ra; logic we; logic [24:0] ma; logic [31:0] wd, dv; int rc; int misses;
    logic [26:0] a;
    logic [31:0] v;
`ifdef DCACHE_STATS_EN
    logic [31:0] h0, m0;
    h0 = hit_count; m0 = miss_count;
`endif
    misses = 0;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 27'h0001100 : 27'h0000100;
      v = 32'hC000_0000 + 32'(i);
      do_access(1'b0, a, 32'h0, 1, v, rs, we, ma, wd, rc, dv, ra);
      if (rs && dv === v && ma === a[26:2]) misses++;
    end
    checks++; if (misses != 4) begin errors++; $display("FAIL conflict_misses got=%0d exp=4", misses); end
`ifdef DCACHE_STATS_EN
    checks++; if (miss_count - m0 !== 32'd4 || hit_count - h0 !== 32'd0) begin
      errors++; $display("FAIL conflict_stats got=miss+%0d hit+%0d exp=miss+4 hit+0", miss_count - m0, hit_count - h0); end
`endif
  endtask

  task automatic test_reset_mid_miss();
    bit rs, ra; logic we; logic [24:0] ma; logic [31:0] wd, dv; int rc; int seen; int quiet;
    @(negedge clk);
    valid_dram = 1'b1; rw_dram = 1'b0; addr_dram = 27'h0004100;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (mem_req) begin seen = 1; break; end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL mid_req got=timeout exp=mem_req"); end
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0 || ready_dram !== 1'b0) begin
      errors++; $display("FAIL rst_vs_ack got=req%b ready%b exp=req0 ready0", mem_req, ready_dram); end
    @(negedge clk);
    mem_ack = 1'b0; valid_dram = 1'b0; rst = 1'b0;
    quiet = 0;
    for (int c = 0; c < 1024; c++) begin
      @(posedge clk);
      #1;
      if (!mem_req && !ready_dram) quiet++;
    end
    checks++; if (quiet != 1024) begin errors++; $display("FAIL reflush_quiet got=%0d exp=1024", quiet); end
    repeat (2) @(posedge clk);
    do_access(1'b0, 27'h0004100, 32'h0, 1, 32'h11112222, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || dv !== 32'h11112222) begin
      errors++; $display("FAIL not_filled got=req%b %h exp=req1 11112222", rs, dv); end
    do_access(1'b0, 27'h0000100, 32'h0, 1, 32'h33334444, rs, we, ma, wd, rc, dv, ra);
    checks++; if (!rs || dv !== 32'h33334444) begin
      errors++; $display("FAIL flushed_line got=req%b %h exp=req1 33334444", rs, dv); end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write();
    test_conflict();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
